// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// default oversampling ratio, baud divisor rounding and 2-of-3 majority vote.
package uart_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Rounded clk-to-sample-tick divisor, computed in 64 bits to avoid overflow.
  function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    longint unsigned den;
    longint unsigned num;
    den = 64'(baud) * 64'(oversample);
    num = 64'(clk_hz) + den / 2;
    return 32'(num / den);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running divide-by-DIV counter producing a one-clk sample-tick enable;
// a synchronous clear realigns the tick phase to a detected start edge.
module uart_rx_tick_gen #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (start, FRAME_DATA_LENGTH data bits, stop), mid-cell sampling.
// Optional: define UART_RX_MAJORITY_EN for a 2-of-3 vote around mid-cell.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned NATIVE_CLK_FREQUENCY = 1000000000,
  parameter int unsigned BAUDRATE             = 9600,
  parameter int unsigned FRAME_DATA_LENGTH    = 8,
  parameter int unsigned BIG_ENDIAN           = 0,
  parameter int unsigned OVERSAMPLE           = DEFAULT_OVERSAMPLE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx,
  output logic [0:FRAME_DATA_LENGTH-1]   data,
  output logic                           valid,
  output logic                           framing_error,
  output logic                           busy
);

  localparam int unsigned DIV = baud_divisor(NATIVE_CLK_FREQUENCY, BAUDRATE, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = (FRAME_DATA_LENGTH > 1) ? $clog2(FRAME_DATA_LENGTH) : 1;

  localparam logic [SW-1:0] CELL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_DATA_LENGTH - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] START_DEC = SW'(OVERSAMPLE / 2);
`else
  localparam logic [SW-1:0] START_DEC = SW'(OVERSAMPLE / 2 - 1);
`endif

  if (DIV < 2) begin : g_div_check
    $error("uart_receiver: clock divisor below 2, raise clk frequency or lower baud rate");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
    $error("uart_receiver: OVERSAMPLE must be even and at least 8");
  end
  if (FRAME_DATA_LENGTH < 2) begin : g_len_check
    $error("uart_receiver: FRAME_DATA_LENGTH must be at least 2");
  end

  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;
  logic rx_p_q, rx_p_d;

  rx_state_e                    state_q, state_d;
  logic [SW-1:0]                sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]                bit_cnt_q, bit_cnt_d;
  logic [0:FRAME_DATA_LENGTH-1] shift_q, shift_d;
  logic [0:FRAME_DATA_LENGTH-1] data_q, data_d;
  logic                         valid_q, valid_d;
  logic                         ferr_q, ferr_d;

  logic tick;
  logic tick_clear;
  logic line_bit;

  uart_rx_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_p_d    = rx_s_q;
  end

`ifdef UART_RX_MAJORITY_EN
  // Holds the two preceding tick samples; the current one completes the vote.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (tick) begin
      hist_d = {hist_q[0], rx_s_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign line_bit = majority3(hist_q[1], hist_q[0], rx_s_q);
`else
  assign line_bit = rx_s_q;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;
    tick_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_p_q && !rx_s_q) begin
          state_d      = START;
          tick_clear   = 1'b1;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
        end
      end

      START: begin
        if (tick) begin
          if (sample_cnt_q == START_DEC) begin
            sample_cnt_d = '0;
            state_d      = line_bit ? IDLE : DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sample_cnt_q == CELL_LAST) begin
            sample_cnt_d = '0;
            if (BIG_ENDIAN != 0) begin
              shift_d = {shift_q[1:FRAME_DATA_LENGTH-1], line_bit};
            end else begin
              shift_d = {line_bit, shift_q[0:FRAME_DATA_LENGTH-2]};
            end
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (sample_cnt_q == CELL_LAST) begin
            sample_cnt_d = '0;
            state_d      = IDLE;
            if (line_bit) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_p_q       <= 1'b1;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_p_q       <= rx_p_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIV=8, 16x oversampling (128 clks per bit);
// the serial line is driven by local tasks standing in for the transmitter.
module tb_uart_receiver;

  localparam int CELL = 128;
`ifdef UART_RX_MAJORITY_EN
  localparam int          LAT        = 75;
  localparam logic [7:0]  GLITCH_EXP = 8'h00;
`else
  localparam int          LAT        = 67;
  localparam logic [7:0]  GLITCH_EXP = 8'h08;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [0:7] data;
  logic       valid;
  logic       framing_error;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  int         valid_cnt     = 0;
  int         ferr_cnt      = 0;
  int         both_cnt      = 0;
  int         wide_cnt      = 0;
  int         busy_rise_cnt = 0;
  logic       valid_prev    = 1'b0;
  logic       busy_prev     = 1'b0;
  logic [7:0] words[$];

  uart_receiver #(
    .NATIVE_CLK_FREQUENCY(1228800),
    .BAUDRATE            (9600),
    .FRAME_DATA_LENGTH   (8),
    .BIG_ENDIAN          (0),
    .OVERSAMPLE          (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      words.push_back(data);
    end
    if (framing_error) ferr_cnt++;
    if (valid && framing_error) both_cnt++;
    if (valid && valid_prev) wide_cnt++;
    if (busy && !busy_prev) busy_rise_cnt++;
    valid_prev = valid;
    busy_prev  = busy;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic send_cell(input logic v);
    rx = v;
    repeat (CELL) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    send_cell(1'b0);
    for (int i = 0; i < 8; i++) send_cell(b[i]);
    send_cell(stop_v);
  endtask

  initial begin
    int v0, f0, b0, n0;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_ferr", framing_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 1: single frame A5 with exact valid timing inside the stop cell
    v0 = valid_cnt; f0 = ferr_cnt;
    send_cell(1'b0);
    for (int i = 0; i < 8; i++) send_cell(((8'hA5 >> i) & 8'h01) != 0);
    rx = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("t1_valid_before", valid, 1'b0);
    @(posedge clk); #1;
    check("t1_valid_pulse", valid, 1'b1);
    check("t1_data_at_valid", data, 8'hA5);
    @(posedge clk); #1;
    check("t1_valid_after", valid, 1'b0);
    check("t1_busy_after_stop", busy, 1'b0);
    repeat (CELL - LAT - 1) @(posedge clk);
    #1;
    send_cell(1'b1);
    check("t1_valid_count", valid_cnt - v0, 1);
    check("t1_ferr_count", ferr_cnt - f0, 0);

    // 2: back-to-back 00 then FF with a single stop bit
    v0 = valid_cnt; f0 = ferr_cnt; n0 = words.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_cell(1'b1);
    check("t2_valid_count", valid_cnt - v0, 2);
    check("t2_ferr_count", ferr_cnt - f0, 0);
    check("t2_word_count", words.size() - n0, 2);
    if (words.size() >= n0 + 2) begin
      check("t2_word0", words[n0], 8'h00);
      check("t2_word1", words[n0+1], 8'hFF);
    end
    check("t2_data", data, 8'hFF);

    // 3: short low pulse rejected at mid start bit
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rise_cnt;
    rx = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("t3_busy_low", busy, 1'b1);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t3_busy_pre_mid", busy, 1'b1);
    repeat (56) @(posedge clk);
    #1;
    check("t3_busy_post_mid", busy, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("t3_busy_rises", busy_rise_cnt - b0, 1);
    check("t3_no_valid", valid_cnt - v0, 0);
    check("t3_no_ferr", ferr_cnt - f0, 0);

    // 4: framing error, line left low (break) afterwards
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_rise_cnt;
    send_frame(8'h3C, 1'b0);
    send_cell(1'b0);
    send_cell(1'b0);
    check("t4_ferr_count", ferr_cnt - f0, 1);
    check("t4_no_valid", valid_cnt - v0, 0);
    check("t4_data_kept", data, 8'hFF);
    check("t4_busy_in_break", busy, 1'b0);
    send_cell(1'b1);
    send_cell(1'b1);
    check("t4_busy_rises", busy_rise_cnt - b0, 1);

    // 5: reset in the middle of data bit 4, then a clean frame
    v0 = valid_cnt; f0 = ferr_cnt;
    send_cell(1'b0);
    for (int i = 0; i < 4; i++) send_cell(((8'hC3 >> i) & 8'h01) != 0);
    rx = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    check("t5_busy_mid_frame", busy, 1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    @(posedge clk); #1;
    check("t5_busy_reset", busy, 1'b0);
    check("t5_data_reset", data, 8'h00);
    check("t5_valid_reset", valid, 1'b0);
    reset = 1'b0;
    send_cell(1'b1);
    send_cell(1'b1);
    check("t5_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    send_frame(8'h5A, 1'b1);
    send_cell(1'b1);
    check("t5_valid_count", valid_cnt - v0, 1);
    check("t5_data", data, 8'h5A);

    // 6: 00 with a one-tick high glitch centred on bit 3
    v0 = valid_cnt; f0 = ferr_cnt;
    send_cell(1'b0);
    for (int i = 0; i < 3; i++) send_cell(1'b0);
    rx = 1'b0;
    repeat (60) @(posedge clk);
    #1; rx = 1'b1;
    repeat (8) @(posedge clk);
    #1; rx = 1'b0;
    repeat (CELL - 68) @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) send_cell(1'b0);
    send_cell(1'b1);
    send_cell(1'b1);
    check("t6_valid_count", valid_cnt - v0, 1);
    check("t6_ferr_count", ferr_cnt - f0, 0);
    check("t6_data", data, GLITCH_EXP);

    check("never_both_pulses", both_cnt, 0);
    check("pulse_width_one", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
